pipe_ctrl_unit: RTL and testbench
=================================

// Module: pipe_ctrl_unit
// PURPOSE
//  Pipelined successor to the single-cycle opcode decoder. Decodes op_i in ID, carries the control
//  bundle through ID/EX, EX/MEM and MEM/WB registers, and inserts bubbles for flush and load-use.
//  Sits beside the datapath pipeline registers. Every output is defined for every opcode.
// PARAMETERS
//  OP_W       6  opcode width
//  RA_W       5  register-address width
//  EN_BNE     1  1: decode bne (000101); 0: treat bne as illegal
//  EN_HAZARD  1  1: internal load-use detection; 0: hazard_stall_o tied 0
// PORTS
//  clk_i          in   1     clock; all state updates on rising edge
//  rst_i          in   1     synchronous reset, active high
//  op_i           in   OP_W  opcode of the instruction in ID
//  rs_i           in   RA_W  rs field of the instruction in ID
//  rt_i           in   RA_W  rt field of the instruction in ID
//  mem_stall_i    in   1     freeze all control pipeline registers this cycle
//  flush_i        in   1     branch/jump taken: bubble into ID/EX
//  id_jump_o      out  1     ID: jump (combinational)
//  id_branch_o    out  1     ID: beq/bne (combinational)
//  id_branch_ne_o out  1     ID: branch on not-equal (combinational)
//  id_ext_op_o    out  1     ID: 1 sign-extend, 0 zero-extend (combinational)
//  illegal_o      out  1     ID: opcode not decoded (combinational)
//  hazard_stall_o out  1     ID: load-use stall; hold PC and IF/ID (combinational)
//  ex_reg_dst_o   out  1     EX: 1 rd, 0 rt
//  ex_alu_src_o   out  1     EX: 1 immediate, 0 rt
//  ex_alu_op_o    out  2     EX: 00 add, 01 sub, 10 or, 11 funct-decoded
//  mem_read_o     out  1     MEM: data-memory read
//  mem_write_o    out  1     MEM: data-memory write
//  wb_reg_write_o out  1     WB: register-file write enable
//  wb_memto_reg_o out  1     WB: 1 memory data, 0 ALU result
// BEHAVIOUR
//  Decode table (RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,BranchNe,Jump,ExtOp,ALUOp):
//   R 000000: 1,0,0,1,0,0,0,0,0,0,11    ori 001101: 0,1,0,1,0,0,0,0,0,0,10
//   addi 001000: 0,1,0,1,0,0,0,0,0,1,00 lw 100011: 0,1,1,1,1,0,0,0,0,1,00
//   sw 101011: 0,1,0,0,0,1,0,0,0,1,00   beq 000100: 0,0,0,0,0,0,1,0,0,1,01
//   bne 000101 (EN_BNE=1): as beq with BranchNe=1     j 000010: all 0 except Jump=1
//   Any other opcode: all 0 (NOP bundle), illegal_o=1.
//  Pipeline: ID/EX holds EX, MEM and WB fields plus ex_rt (RA_W). EX/MEM holds MEM and WB fields.
//   MEM/WB holds WB fields. Each stage output is taken directly from its register.
//   Latency: op_i decoded at edge N drives EX at N+1, MEM at N+2, WB at N+3.
//  Load-use: hazard_stall_o = EN_HAZARD & ID/EX.mem_read & (ex_rt!=0) & (ex_rt==rs_i |
//   (ex_rt==rt_i & op_i in {R,beq,bne,sw})). Stall lasts exactly one cycle per load.
//  Per-edge priority, highest first:
//   1. rst_i: all pipeline registers cleared (bubble). All registered outputs 0 the next cycle.
//   2. mem_stall_i: all three registers hold. The hazard/flush bubble is deferred, not lost.
//   3. flush_i or hazard_stall_o: ID/EX loads bubble. EX/MEM and MEM/WB advance normally.
//   4. Otherwise ID/EX loads the decoded bundle, EX/MEM <= ID/EX, and MEM/WB <= EX/MEM.
//  A bubble has all control fields 0 and ex_rt=0. It never writes memory or the register file.
//  illegal opcode: its NOP bundle flows down the pipe. illegal_o reflects only the current ID opcode.
//  Combinational ID outputs depend only on op_i, rs_i, rt_i and ID/EX state, and are valid during rst_i.
//  Mid-operation reset: in-flight lw/sw are discarded, and mem_*_o are 0 from the next cycle.
// TESTING
//  1. rst_i=1 two cycles, then op_i=lw -> EX/MEM/WB outputs 0 during reset; lw fields in EX at +1, MEM at +2, WB at +3.
//  2. Sequence R,ori,addi,lw,sw,beq,bne,j -> each stage output matches the decode table with 1/2/3-cycle delay.
//  3. lw rt=5, then add rs=5 -> hazard_stall_o=1 for one cycle, bubble in EX, then add decoded; repeat with rt=0 -> no stall.
//  4. op_i=111111 -> illegal_o=1, NOP bundle in pipeline; EN_BNE=0 with op_i=000101 -> illegal_o=1.
//  5. mem_stall_i=1 for 3 cycles with lw in EX/MEM -> mem_read_o held 1, no stage advances; flush_i with mem_stall_i -> hold wins.
//  6. sw in EX/MEM and rst_i=1 -> mem_write_o=0 next cycle, wb_reg_write_o=0.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
// ============================================================================
//  Module   : pipe_ctrl_unit
//  Brief    : Pipelined control decoder with flush and load-use bubble logic.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_ctrl_unit #(
    parameter int OP_W      = 6,
    parameter int RA_W      = 5,
    parameter int EN_BNE    = 1,
    parameter int EN_HAZARD = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [OP_W-1:0] op_i,
    input  logic [RA_W-1:0] rs_i,
    input  logic [RA_W-1:0] rt_i,
    input  logic            mem_stall_i,
    input  logic            flush_i,
    output logic            id_jump_o,
    output logic            id_branch_o,
    output logic            id_branch_ne_o,
    output logic            id_ext_op_o,
    output logic            illegal_o,
    output logic            hazard_stall_o,
    output logic            ex_reg_dst_o,
    output logic            ex_alu_src_o,
    output logic [1:0]      ex_alu_op_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    output logic            wb_reg_write_o,
    output logic            wb_memto_reg_o
);

    localparam logic [OP_W-1:0] c_OP_R    = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] c_OP_J    = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] c_OP_BEQ  = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] c_OP_BNE  = OP_W'(6'b000101);
    localparam logic [OP_W-1:0] c_OP_ADDI = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] c_OP_ORI  = OP_W'(6'b001101);
    localparam logic [OP_W-1:0] c_OP_LW   = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] c_OP_SW   = OP_W'(6'b101011);

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       memto_reg;
    } ctrl_t;

    ctrl_t           w_dec;
    logic            w_jump;
    logic            w_branch;
    logic            w_branch_ne;
    logic            w_ext_op;
    logic            w_illegal;
    logic            w_uses_rt;
    logic            w_hazard;

    ctrl_t           r_idex;
    logic [RA_W-1:0] r_idex_rt;
    logic            r_exmem_mem_read;
    logic            r_exmem_mem_write;
    logic            r_exmem_reg_write;
    logic            r_exmem_memto_reg;
    logic            r_memwb_reg_write;
    logic            r_memwb_memto_reg;

    always_comb begin
        w_dec       = '0;
        w_jump      = 1'b0;
        w_branch    = 1'b0;
        w_branch_ne = 1'b0;
        w_ext_op    = 1'b0;
        w_illegal   = 1'b0;
        case (op_i)
            c_OP_R: begin
                w_dec.reg_dst   = 1'b1;
                w_dec.reg_write = 1'b1;
                w_dec.alu_op    = 2'b11;
            end
            c_OP_ORI: begin
                w_dec.alu_src   = 1'b1;
                w_dec.reg_write = 1'b1;
                w_dec.alu_op    = 2'b10;
            end
            c_OP_ADDI: begin
                w_dec.alu_src   = 1'b1;
                w_dec.reg_write = 1'b1;
                w_ext_op        = 1'b1;
            end
            c_OP_LW: begin
                w_dec.alu_src   = 1'b1;
                w_dec.memto_reg = 1'b1;
                w_dec.reg_write = 1'b1;
                w_dec.mem_read  = 1'b1;
                w_ext_op        = 1'b1;
            end
            c_OP_SW: begin
                w_dec.alu_src   = 1'b1;
                w_dec.mem_write = 1'b1;
                w_ext_op        = 1'b1;
            end
            c_OP_BEQ: begin
                w_dec.alu_op = 2'b01;
                w_branch     = 1'b1;
                w_ext_op     = 1'b1;
            end
            c_OP_BNE: begin
                if (EN_BNE != 0) begin
                    w_dec.alu_op = 2'b01;
                    w_branch     = 1'b1;
                    w_branch_ne  = 1'b1;
                    w_ext_op     = 1'b1;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            c_OP_J: begin
                w_jump = 1'b1;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // Only instructions that actually read rt as a source can stall on an rt match.
    assign w_uses_rt = (op_i == c_OP_R) || (op_i == c_OP_BEQ) ||
                       (op_i == c_OP_BNE) || (op_i == c_OP_SW);

    assign w_hazard = (EN_HAZARD != 0) && r_idex.mem_read && (r_idex_rt != '0) &&
                      ((r_idex_rt == rs_i) || ((r_idex_rt == rt_i) && w_uses_rt));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_idex            <= '0;
            r_idex_rt         <= '0;
            r_exmem_mem_read  <= 1'b0;
            r_exmem_mem_write <= 1'b0;
            r_exmem_reg_write <= 1'b0;
            r_exmem_memto_reg <= 1'b0;
            r_memwb_reg_write <= 1'b0;
            r_memwb_memto_reg <= 1'b0;
        end else if (!mem_stall_i) begin
            // A held hazard keeps w_hazard high, so its bubble lands once the stall drops.
            if (flush_i || w_hazard) begin
                r_idex    <= '0;
                r_idex_rt <= '0;
            end else begin
                r_idex    <= w_dec;
                r_idex_rt <= rt_i;
            end
            r_exmem_mem_read  <= r_idex.mem_read;
            r_exmem_mem_write <= r_idex.mem_write;
            r_exmem_reg_write <= r_idex.reg_write;
            r_exmem_memto_reg <= r_idex.memto_reg;
            r_memwb_reg_write <= r_exmem_reg_write;
            r_memwb_memto_reg <= r_exmem_memto_reg;
        end
    end

    assign id_jump_o      = w_jump;
    assign id_branch_o    = w_branch;
    assign id_branch_ne_o = w_branch_ne;
    assign id_ext_op_o    = w_ext_op;
    assign illegal_o      = w_illegal;
    assign hazard_stall_o = w_hazard;
    assign ex_reg_dst_o   = r_idex.reg_dst;
    assign ex_alu_src_o   = r_idex.alu_src;
    assign ex_alu_op_o    = r_idex.alu_op;
    assign mem_read_o     = r_exmem_mem_read;
    assign mem_write_o    = r_exmem_mem_write;
    assign wb_reg_write_o = r_memwb_reg_write;
    assign wb_memto_reg_o = r_memwb_memto_reg;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
// ============================================================================
//  Module   : tb_pipe_ctrl_unit
//  Brief    : Directed scoreboard bench for pipe_ctrl_unit.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl_unit;

    localparam logic [5:0] c_R    = 6'h00;
    localparam logic [5:0] c_J    = 6'h02;
    localparam logic [5:0] c_BEQ  = 6'h04;
    localparam logic [5:0] c_BNE  = 6'h05;
    localparam logic [5:0] c_ADDI = 6'h08;
    localparam logic [5:0] c_ORI  = 6'h0D;
    localparam logic [5:0] c_LW   = 6'h23;
    localparam logic [5:0] c_SW   = 6'h2B;
    localparam logic [5:0] c_ILL  = 6'h3F;

    logic       clk;
    logic       rst;
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       ms;
    logic       fl;

    logic       jump, branch, branch_ne, ext_op, illegal, hazard;
    logic       ex_reg_dst, ex_alu_src, mem_read, mem_write, wb_reg_write, wb_memto_reg;
    logic [1:0] ex_alu_op;

    logic       jump2, branch2, branch_ne2, ext_op2, illegal2, hazard2;
    logic       ex_reg_dst2, ex_alu_src2, mem_read2, mem_write2, wb_reg_write2, wb_memto_reg2;
    logic [1:0] ex_alu_op2;

    int tests = 0;
    int fails = 0;

    // Bundle layout: {reg_dst, alu_src, alu_op[1:0], mem_read, mem_write, reg_write, memto_reg}
    logic [7:0] exp_q[$];
    logic [7:0] cur_ex, cur_mem, cur_wb;

    pipe_ctrl_unit #(.OP_W(6), .RA_W(5), .EN_BNE(1), .EN_HAZARD(1)) dut (
        .clk_i(clk), .rst_i(rst), .op_i(op), .rs_i(rs), .rt_i(rt),
        .mem_stall_i(ms), .flush_i(fl),
        .id_jump_o(jump), .id_branch_o(branch), .id_branch_ne_o(branch_ne),
        .id_ext_op_o(ext_op), .illegal_o(illegal), .hazard_stall_o(hazard),
        .ex_reg_dst_o(ex_reg_dst), .ex_alu_src_o(ex_alu_src), .ex_alu_op_o(ex_alu_op),
        .mem_read_o(mem_read), .mem_write_o(mem_write),
        .wb_reg_write_o(wb_reg_write), .wb_memto_reg_o(wb_memto_reg)
    );

    pipe_ctrl_unit #(.OP_W(6), .RA_W(5), .EN_BNE(0), .EN_HAZARD(0)) dut2 (
        .clk_i(clk), .rst_i(rst), .op_i(op), .rs_i(rs), .rt_i(rt),
        .mem_stall_i(ms), .flush_i(fl),
        .id_jump_o(jump2), .id_branch_o(branch2), .id_branch_ne_o(branch_ne2),
        .id_ext_op_o(ext_op2), .illegal_o(illegal2), .hazard_stall_o(hazard2),
        .ex_reg_dst_o(ex_reg_dst2), .ex_alu_src_o(ex_alu_src2), .ex_alu_op_o(ex_alu_op2),
        .mem_read_o(mem_read2), .mem_write_o(mem_write2),
        .wb_reg_write_o(wb_reg_write2), .wb_memto_reg_o(wb_memto_reg2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {bundle[7:0], jump, branch, branch_ne, ext_op, illegal} from the decode table.
    function automatic logic [12:0] dec(input logic [5:0] o);
        case (o)
            c_R:     dec = {8'b1_0_11_0_0_1_0, 5'b00000};
            c_ORI:   dec = {8'b0_1_10_0_0_1_0, 5'b00000};
            c_ADDI:  dec = {8'b0_1_00_0_0_1_0, 5'b00010};
            c_LW:    dec = {8'b0_1_00_1_0_1_1, 5'b00010};
            c_SW:    dec = {8'b0_1_00_0_1_0_0, 5'b00010};
            c_BEQ:   dec = {8'b0_0_01_0_0_0_0, 5'b01010};
            c_BNE:   dec = {8'b0_0_01_0_0_0_0, 5'b01110};
            c_J:     dec = {8'b0_0_00_0_0_0_0, 5'b10000};
            default: dec = {8'b0_0_00_0_0_0_0, 5'b00001};
        endcase
    endfunction

    task automatic step(input logic r, input logic [5:0] o, input logic [4:0] s,
                        input logic [4:0] t, input logic m, input logic f,
                        input logic exp_haz);
        logic [12:0] d;
        logic [7:0]  nxt_ex, nxt_mem, nxt_wb;
        logic [7:0]  id_obs, id_exp, st_obs, st_exp;
        @(negedge clk);
        rst = r; op = o; rs = s; rt = t; ms = m; fl = f;
        #1;
        d      = dec(o);
        id_obs = {jump, branch, branch_ne, ext_op, illegal, hazard, illegal2, hazard2};
        id_exp = {d[4:0], exp_haz, d[0] | (o == c_BNE), 1'b0};
        tests++;
        assert (id_obs === id_exp) else begin
            fails++;
            $error("FAIL id_ctrl op=%h obs=%b exp=%b", o, id_obs, id_exp);
        end
        if (r) begin
            nxt_ex = '0; nxt_mem = '0; nxt_wb = '0;
        end else if (m) begin
            nxt_ex = cur_ex; nxt_mem = cur_mem; nxt_wb = cur_wb;
        end else begin
            nxt_wb  = cur_mem;
            nxt_mem = cur_ex;
            nxt_ex  = (f || exp_haz) ? 8'h00 : d[12:5];
        end
        exp_q.push_back(nxt_ex);
        @(posedge clk);
        #1;
        cur_ex  = exp_q.pop_front();
        cur_mem = nxt_mem;
        cur_wb  = nxt_wb;
        st_obs  = {ex_reg_dst, ex_alu_src, ex_alu_op, mem_read, mem_write,
                   wb_reg_write, wb_memto_reg};
        st_exp  = {cur_ex[7:4], cur_mem[3:2], cur_wb[1:0]};
        tests++;
        assert (st_obs === st_exp) else begin
            fails++;
            $error("FAIL stages op=%h obs=%b exp=%b", o, st_obs, st_exp);
        end
    endtask

    initial begin
        rst = 1'b1; op = c_LW; rs = '0; rt = '0; ms = 1'b0; fl = 1'b0;
        cur_ex = '0; cur_mem = '0; cur_wb = '0;
        @(posedge clk);
        // Reset held, then lw flows EX/MEM/WB
        step(1, c_LW, 1, 2, 0, 0, 0);
        step(1, c_LW, 1, 2, 0, 0, 0);
        step(0, c_LW, 1, 2, 0, 0, 0);
        step(0, c_ORI, 0, 0, 0, 0, 0);
        step(0, c_ORI, 0, 0, 0, 0, 0);
        // Full opcode sweep
        step(0, c_R, 1, 1, 0, 0, 0);
        step(0, c_ORI, 1, 1, 0, 0, 0);
        step(0, c_ADDI, 1, 1, 0, 0, 0);
        step(0, c_LW, 1, 3, 0, 0, 0);
        step(0, c_SW, 4, 6, 0, 0, 0);
        step(0, c_BEQ, 1, 1, 0, 0, 0);
        step(0, c_BNE, 1, 1, 0, 0, 0);
        step(0, c_J, 0, 0, 0, 0, 0);
        step(0, c_ILL, 0, 0, 0, 0, 0);
        step(0, c_ILL, 0, 0, 0, 0, 0);
        step(0, c_ILL, 0, 0, 0, 0, 0);
        // Load-use on rs, then on rt, then non-stalling cases
        step(0, c_LW, 1, 5, 0, 0, 0);
        step(0, c_R, 5, 7, 0, 0, 1);
        step(0, c_R, 5, 7, 0, 0, 0);
        step(0, c_LW, 1, 5, 0, 0, 0);
        step(0, c_SW, 1, 5, 0, 0, 1);
        step(0, c_SW, 1, 5, 0, 0, 0);
        step(0, c_LW, 1, 5, 0, 0, 0);
        step(0, c_ORI, 1, 5, 0, 0, 0);
        step(0, c_LW, 1, 0, 0, 0, 0);
        step(0, c_R, 0, 0, 0, 0, 0);
        // Memory stall holds everything; flush loses to hold
        step(0, c_LW, 1, 2, 0, 0, 0);
        step(0, c_ORI, 0, 0, 0, 0, 0);
        step(0, c_ORI, 0, 0, 1, 0, 0);
        step(0, c_ORI, 0, 0, 1, 1, 0);
        step(0, c_ORI, 0, 0, 1, 0, 0);
        step(0, c_ORI, 0, 0, 0, 0, 0);
        // Hazard raised during stall is deferred, not lost
        step(0, c_LW, 1, 5, 0, 0, 0);
        step(0, c_R, 5, 1, 1, 0, 1);
        step(0, c_R, 5, 1, 0, 0, 1);
        step(0, c_R, 5, 1, 0, 0, 0);
        step(0, c_ADDI, 1, 1, 0, 1, 0);
        step(0, c_ORI, 0, 0, 0, 0, 0);
        // Reset with sw in EX/MEM discards it
        step(0, c_SW, 1, 2, 0, 0, 0);
        step(0, c_ORI, 0, 0, 0, 0, 0);
        step(1, c_ORI, 0, 0, 0, 0, 0);
        step(0, c_ORI, 0, 0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
